// File: rtl/box_sum_query_pkg.sv
// rtl/box_sum_query_pkg.sv - shared FSM/corner types and geometry constants for box_sum_query
package box_sum_query_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CAPTURE,
    COMBINE,
    RESULT
  } state_t;

  typedef enum logic [1:0] {
    CORNER_D,
    CORNER_B,
    CORNER_C,
    CORNER_A
  } corner_t;

  localparam int IMG_W_LOG2 = 2;

  function automatic corner_t next_corner(input corner_t c);
    case (c)
      CORNER_D: next_corner = CORNER_B;
      CORNER_B: next_corner = CORNER_C;
      CORNER_C: next_corner = CORNER_A;
      default:  next_corner = CORNER_D;
    endcase
  endfunction

endpackage

// File: rtl/box_corner_addr.sv
// rtl/box_corner_addr.sv - maps latched rectangle and corner index to integral-image address
module box_corner_addr
  import box_sum_query_pkg::*;
#(
  parameter int COORD_W = 2,
  parameter int ADDR_W  = 8,
  parameter int SHIFT   = IMG_W_LOG2
) (
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  input  logic [1:0]         corner,
  output logic [ADDR_W-1:0]  addr,
  output logic               needed
);

  logic [COORD_W-1:0] row;
  logic [COORD_W-1:0] col;

  // Corners on row -1 or column -1 contribute zero and are never read.
  always_comb begin
    row    = y1;
    col    = x1;
    needed = 1'b1;
    case (corner_t'(corner))
      CORNER_B: begin
        row    = y0 - COORD_W'(1);
        needed = (y0 != '0);
      end
      CORNER_C: begin
        col    = x0 - COORD_W'(1);
        needed = (x0 != '0);
      end
      CORNER_A: begin
        row    = y0 - COORD_W'(1);
        col    = x0 - COORD_W'(1);
        needed = (x0 != '0) && (y0 != '0);
      end
      default: ;
    endcase
  end

  assign addr = (ADDR_W'(row) << SHIFT) + ADDR_W'(col);

endmodule

// File: rtl/box_sum_query.sv
// rtl/box_sum_query.sv - rectangle sum from an integral image held in a 2-cycle M10K
module box_sum_query
  import box_sum_query_pkg::*;
#(
  parameter int IMG_W   = 4,
  parameter int IMG_H   = 4,
  parameter int COORD_W = 2,
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       query_valid,
  output logic                       query_ready,
  input  logic [COORD_W-1:0]         x0,
  input  logic [COORD_W-1:0]         y0,
  input  logic [COORD_W-1:0]         x1,
  input  logic [COORD_W-1:0]         y1,
  output logic                       result_valid,
  input  logic                       result_ready,
  output logic signed [DATA_W+1:0]   result_sum,
  output logic                       result_err,
  output logic [ADDR_W-1:0]          M10K_read_address_int,
  input  logic signed [DATA_W-1:0]   M10K_read_data_int
);

  state_t             state;
  state_t             state_next;
  corner_t            corner;
  logic [COORD_W-1:0] lat_x0;
  logic [COORD_W-1:0] lat_y0;
  logic [COORD_W-1:0] lat_x1;
  logic [COORD_W-1:0] lat_y1;
  logic signed [DATA_W+1:0] corner_val [4];
  logic [ADDR_W-1:0]  corner_addr;
  logic               corner_needed;
  logic               coords_ok;
  logic               accept;

  box_corner_addr #(
    .COORD_W (COORD_W),
    .ADDR_W  (ADDR_W),
    .SHIFT   (IMG_W_LOG2)
  ) u_corner_addr (
    .x0     (lat_x0),
    .y0     (lat_y0),
    .x1     (lat_x1),
    .y1     (lat_y1),
    .corner (corner),
    .addr   (corner_addr),
    .needed (corner_needed)
  );

  assign accept    = query_valid && query_ready;
  assign coords_ok = (lat_x0 <= lat_x1) && (lat_y0 <= lat_y1) &&
                     (32'(lat_x1) < IMG_W) && (32'(lat_y1) < IMG_H);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ISSUE;
      ISSUE:   state_next = (corner == CORNER_D && !coords_ok) ? RESULT : WAIT;
      WAIT:    state_next = CAPTURE;
      CAPTURE: state_next = (corner == CORNER_A) ? COMBINE : ISSUE;
      COMBINE: state_next = RESULT;
      RESULT:  if (result_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state                 <= IDLE;
      query_ready           <= 1'b0;
      result_valid          <= 1'b0;
      result_err            <= 1'b0;
      result_sum            <= '0;
      M10K_read_address_int <= '0;
      corner                <= CORNER_D;
      lat_x0                <= '0;
      lat_y0                <= '0;
      lat_x1                <= '0;
      lat_y1                <= '0;
      for (int i = 0; i < 4; i++) corner_val[i] <= '0;
    end else begin
      state        <= state_next;
      query_ready  <= (state_next == IDLE);
      result_valid <= (state_next == RESULT);
      case (state)
        IDLE: if (accept) begin
          lat_x0     <= x0;
          lat_y0     <= y0;
          lat_x1     <= x1;
          lat_y1     <= y1;
          corner     <= CORNER_D;
          result_err <= 1'b0;
        end
        ISSUE: begin
          // Validity is judged on the first corner so a bad query never reads.
          if (corner == CORNER_D && !coords_ok) begin
            result_err <= 1'b1;
            result_sum <= '0;
          end else if (corner_needed) begin
            M10K_read_address_int <= corner_addr;
          end
        end
        CAPTURE: begin
          corner_val[corner] <= corner_needed ?
            {{2{M10K_read_data_int[DATA_W-1]}}, M10K_read_data_int} : '0;
          corner <= next_corner(corner);
        end
        COMBINE: result_sum <= corner_val[CORNER_D] - corner_val[CORNER_B]
                               - corner_val[CORNER_C] + corner_val[CORNER_A];
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_box_sum_query.sv
// tb/tb_box_sum_query.sv - randomized self-checking bench for box_sum_query
module tb_box_sum_query;

  localparam int IMG_W   = 4;
  localparam int IMG_H   = 4;
  localparam int COORD_W = 2;
  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 8;

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic                     query_valid = 1'b0;
  logic                     query_ready;
  logic [COORD_W-1:0]       x0 = '0;
  logic [COORD_W-1:0]       y0 = '0;
  logic [COORD_W-1:0]       x1 = '0;
  logic [COORD_W-1:0]       y1 = '0;
  logic                     result_valid;
  logic                     result_ready = 1'b1;
  logic signed [DATA_W+1:0] result_sum;
  logic                     result_err;
  logic [ADDR_W-1:0]        M10K_read_address_int;
  logic signed [DATA_W-1:0] M10K_read_data_int;

  int n_checks = 0;
  int n_fail   = 0;

  logic signed [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0]        mem_addr_q = '0;
  int                       src [IMG_H][IMG_W];
  int                       addr_log [$];
  logic [ADDR_W-1:0]        last_addr = '0;

  box_sum_query #(
    .IMG_W (IMG_W), .IMG_H (IMG_H), .COORD_W (COORD_W), .DATA_W (DATA_W), .ADDR_W (ADDR_W)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .query_valid           (query_valid),
    .query_ready           (query_ready),
    .x0                    (x0),
    .y0                    (y0),
    .x1                    (x1),
    .y1                    (y1),
    .result_valid          (result_valid),
    .result_ready          (result_ready),
    .result_sum            (result_sum),
    .result_err            (result_err),
    .M10K_read_address_int (M10K_read_address_int),
    .M10K_read_data_int    (M10K_read_data_int)
  );

  always #5 clk = ~clk;

  // M10K: registered address, data two cycles after the DUT's address register updates.
  always @(posedge clk) mem_addr_q <= M10K_read_address_int;
  assign M10K_read_data_int = mem[mem_addr_q];

  always @(negedge clk) begin
    if (M10K_read_address_int !== last_addr) begin
      addr_log.push_back(int'(M10K_read_address_int));
      last_addr = M10K_read_address_int;
    end
  end

  task automatic check(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s.%s observed=%0d expected=%0d", tag, what, $signed(obs), $signed(exp));
    end
  endtask

  task automatic load_mem();
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++) begin
        int s;
        s = 0;
        for (int i = 0; i <= r; i++)
          for (int j = 0; j <= c; j++) s += src[i][j];
        mem[r*IMG_W + c] = DATA_W'(s);
      end
  endtask

  function automatic int rect_sum(input int qx0, input int qy0, input int qx1, input int qy1);
    int s;
    s = 0;
    for (int r = qy0; r <= qy1; r++)
      for (int c = qx0; c <= qx1; c++) s += src[r][c];
    return s;
  endfunction

  task automatic run_query(input int qx0, input int qy0, input int qx1, input int qy1,
                           input int hold, input string tag);
    bit bad;
    int exp_sum, exp_lat, lat, prev, w;
    int exp_addrs [$];
    int rows [4];
    int cols [4];
    bit need [4];
    bad = (qx0 > qx1) || (qy0 > qy1) || (qx1 >= IMG_W) || (qy1 >= IMG_H);
    result_ready = (hold == 0);
    @(negedge clk);
    w = 0;
    while (query_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    check(tag, "query_ready_idle", 32'(query_ready), 1);
    prev = int'(M10K_read_address_int);
    if (!bad) begin
      rows = '{qy1, qy0 - 1, qy1, qy0 - 1};
      cols = '{qx1, qx1, qx0 - 1, qx0 - 1};
      need = '{1'b1, qy0 > 0, qx0 > 0, (qx0 > 0) && (qy0 > 0)};
      for (int k = 0; k < 4; k++)
        if (need[k]) begin
          int a;
          a = rows[k]*IMG_W + cols[k];
          if (a != prev) exp_addrs.push_back(a);
          prev = a;
        end
    end
    exp_sum = bad ? 0 : rect_sum(qx0, qy0, qx1, qy1);
    exp_lat = bad ? 1 : 13;
    query_valid = 1'b1;
    x0 = COORD_W'(qx0);
    y0 = COORD_W'(qy0);
    x1 = COORD_W'(qx1);
    y1 = COORD_W'(qy1);
    @(posedge clk);
    #1;
    query_valid = 1'b0;
    x0 = COORD_W'($urandom);
    y0 = COORD_W'($urandom);
    x1 = COORD_W'($urandom);
    y1 = COORD_W'($urandom);
    addr_log.delete();
    lat = 0;
    for (int i = 1; i <= 30 && lat == 0; i++) begin
      @(posedge clk);
      #1;
      if (result_valid === 1'b1) lat = i;
    end
    check(tag, "latency", lat, exp_lat);
    check(tag, "sum", 32'($signed(result_sum)), exp_sum);
    check(tag, "err", 32'(result_err), 32'(bad));
    check(tag, "n_reads", addr_log.size(), exp_addrs.size());
    for (int k = 0; k < exp_addrs.size(); k++)
      check(tag, "addr", (addr_log.size() > k) ? addr_log[k] : -1, exp_addrs[k]);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check(tag, "hold_valid", 32'(result_valid), 1);
      check(tag, "hold_sum", 32'($signed(result_sum)), exp_sum);
      check(tag, "hold_err", 32'(result_err), 32'(bad));
      check(tag, "hold_qready", 32'(query_ready), 0);
    end
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    check(tag, "post_valid", 32'(result_valid), 0);
    check(tag, "post_qready", 32'(query_ready), 1);
  endtask

  initial begin
    int w;
    for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = '0;
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++) src[r][c] = 1;
    load_mem();

    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset", "query_ready", 32'(query_ready), 0);
    check("reset", "result_valid", 32'(result_valid), 0);
    check("reset", "result_err", 32'(result_err), 0);
    check("reset", "result_sum", 32'($signed(result_sum)), 0);
    check("reset", "address", 32'(M10K_read_address_int), 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("reset", "first_ready", 32'(query_ready), 1);

    run_query(1, 1, 2, 2, 0, "ones_1122");
    run_query(0, 0, 3, 3, 0, "ones_full");
    run_query(3, 3, 3, 3, 0, "ones_3333");
    run_query(2, 0, 1, 3, 0, "bad_x");
    run_query(0, 1, 2, 3, 5, "hold");
    run_query(1, 0, 3, 2, 0, "b2b");

    // Abort a query while corner B is in WAIT.
    @(negedge clk);
    w = 0;
    while (query_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    query_valid = 1'b1;
    x0 = 2'd1; y0 = 2'd1; x1 = 2'd3; y1 = 2'd3;
    @(posedge clk);
    #1;
    query_valid = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("midrst", "query_ready", 32'(query_ready), 0);
    check("midrst", "result_valid", 32'(result_valid), 0);
    check("midrst", "result_err", 32'(result_err), 0);
    check("midrst", "result_sum", 32'($signed(result_sum)), 0);
    check("midrst", "address", 32'(M10K_read_address_int), 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst", "ready_after", 32'(query_ready), 1);
    check("midrst", "no_result", 32'(result_valid), 0);
    run_query(1, 1, 3, 3, 0, "after_rst");

    for (int n = 0; n < 12; n++) begin
      for (int r = 0; r < IMG_H; r++)
        for (int c = 0; c < IMG_W; c++) src[r][c] = int'($urandom_range(15)) - 8;
      load_mem();
      run_query(int'($urandom_range(3)), int'($urandom_range(3)),
                int'($urandom_range(3)), int'($urandom_range(3)),
                int'($urandom_range(2)), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/box_sum_query.md
BOX_SUM_QUERY -- requirements
Module: box_sum_query

Interface
REQ-001 SHALL have parameters (name, default, meaning): IMG_W, 4, image width in pixels (power of 2); IMG_H, 4, image height in pixels; COORD_W, 2, coordinate width; DATA_W, 8, integral-image word width; ADDR_W, 8, M10K address width.
REQ-002 SHALL have ports clk, input, 1, single clock; reset, input, 1, synchronous active-low reset (asserted when 0).
REQ-003 SHALL have ports query_valid, input, 1; query_ready, output, 1; x0, y0, x1, y1, input, COORD_W each, inclusive rectangle corners.
REQ-004 SHALL have ports result_valid, output, 1; result_ready, input, 1; result_sum, output, DATA_W+2 signed; result_err, output, 1, invalid rectangle.
REQ-005 SHALL have ports M10K_read_address_int, output, ADDR_W, integral-image read address; M10K_read_data_int, input, DATA_W signed, integral-image read data.

Function
REQ-006 SHALL compute the sum over the rectangle as D - B - C + A, where I(r,c) is the integral word at address r*IMG_W + c, and D=I(y1,x1), B=I(y0-1,x1), C=I(y1,x0-1), A=I(y0-1,x0-1).
REQ-007 SHALL treat B as 0 when y0=0, C as 0 when x0=0, and A as 0 when x0=0 or y0=0; no read SHALL be issued for a zero corner.
REQ-008 SHALL sign-extend all corner values to DATA_W+2 and use two's-complement arithmetic at that width, with no saturation.
REQ-009 SHALL assert query_ready only in IDLE; a query SHALL be accepted on a clock edge where query_valid and query_ready are both 1, and x0..y1 SHALL be latched at that edge.
REQ-010 SHALL use FSM states IDLE, ISSUE, WAIT, CAPTURE, COMBINE, RESULT, with corners processed in the order D, B, C, A.
REQ-011 SHALL step each corner through ISSUE, WAIT, CAPTURE (3 cycles): ISSUE registers the address, and CAPTURE samples M10K_read_data_int exactly 2 cycles after that address update.
REQ-012 SHALL spend the same 3 cycles on a skipped corner, capture 0, and leave the address unchanged, giving a fixed latency.
REQ-013 SHALL register result_sum in COMBINE and SHALL raise result_valid 13 clocks after the acceptance edge.
REQ-014 SHALL treat a query with x0>x1, y0>y1, x>=IMG_W or y>=IMG_H as invalid: no reads, result_err=1, result_sum=0, and result_valid asserted 1 clock after acceptance.
REQ-015 SHALL hold result_sum, result_err and result_valid stable while result_valid=1 and result_ready=0.
REQ-016 SHALL return to IDLE on the edge where result_valid and result_ready are both 1; query_ready SHALL rise the following cycle, with no same-cycle bypass.
REQ-017 SHALL drive result_err=0 for valid queries.
REQ-018 SHALL ignore query_valid outside IDLE, and SHALL ignore changes to x0..y1 after acceptance.

Reset
REQ-019 SHALL, while reset=0 at a clock edge, set state=IDLE, query_ready=0, result_valid=0, result_err=0, result_sum=0, M10K_read_address_int=0 and all corner registers to 0.
REQ-020 SHALL discard any in-flight query when reset is asserted mid-operation; no result SHALL be produced for it.
REQ-021 SHALL assert query_ready on the first cycle after reset deasserts.

Structure
REQ-022 SHALL place in a shared package the FSM state enum, the corner index enum (D, B, C, A), and the localparam for log2(IMG_W).
REQ-023 SHALL contain one sub-module, box_corner_addr, which maps (latched coords, corner index) to {address, needed flag} combinationally.
REQ-024 SHALL form addresses as (row << log2(IMG_W)) + col, with explicit parenthesisation.

Verification
REQ-025 SHALL cover: M10K model (2-cycle latency) preloaded with I(r,c)=(r+1)(c+1) (all-ones source), query (1,1)-(2,2) -> result_sum=4, reads at addresses 10, 2, 8, 0, result_valid 13 clocks after accept.
REQ-026 SHALL cover: same memory, query (0,0)-(3,3) -> result_sum=16, exactly one read (address 15), latency still 13.
REQ-027 SHALL cover: query (3,3)-(3,3) -> D=16, B=12, C=12, A=9, result_sum=1.
REQ-028 SHALL cover: query x0=2, x1=1 -> result_err=1, result_sum=0, result_valid 1 clock after accept, no address change.
REQ-029 SHALL cover: result_ready held 0 for 5 cycles -> outputs stable, query_ready=0; then ready=1 -> query_ready=1 the next cycle, and a back-to-back second query returns the correct sum.
REQ-030 SHALL cover: reset=0 during WAIT of corner B -> all outputs at reset values next cycle, no result_valid for that query; a new query afterwards returns the correct sum.
